// File: rtl/ioports_cmd_arbiter.sv
// Round-robin sequencer sharing the port block byte command interface between two word requesters; IOARB_TIMEOUT_EN adds a read timeout.
// Write ack at T+6 (T+6+GAP_CYCLES for port 15), reads gated by ready/enout handshakes; requesters wait on held req until ack.
module ioports_cmd_arbiter #(
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [3:0]  addr0,
    input  logic [3:0]  addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata,
    output logic        err,
    output logic        load,
    output logic [7:0]  datain,
    output logic        ready,
    input  logic        enout,
    input  logic [7:0]  dataout
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_WBYTE, S_GAP, S_RD_REQ, S_RD_LOW, S_DONE
    } state_t;

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  bc_q, bc_d;
    logic [3:0]  gap_q, gap_d;
    logic        last_q, last_d;
    logic        gnt_q, gnt_d;
    logic        we_q, we_d;
    logic [3:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] shift_q, shift_d;
    logic        timed_out;

    logic        load_q, load_d;
    logic [7:0]  datain_q, datain_d;
    logic        ready_q, ready_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

`ifdef IOARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;

    always_ff @(posedge clk) begin
        if (reset) tmo_q <= '0;
        else       tmo_q <= tmo_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            bc_q     <= 2'd0;
            gap_q    <= 4'd0;
            last_q   <= 1'b1;
            gnt_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 4'd0;
            wdata_q  <= 32'd0;
            shift_q  <= 32'd0;
            load_q   <= 1'b0;
            datain_q <= 8'd0;
            ready_q  <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bc_q     <= bc_d;
            gap_q    <= gap_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            shift_q  <= shift_d;
            load_q   <= load_d;
            datain_q <= datain_d;
            ready_q  <= ready_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bc_d      = bc_q;
        gap_d     = gap_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        shift_d   = shift_q;
        timed_out = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    // req1 wins only when req0 is absent or req0 was served last
                    gnt_d   = req1 && (!req0 || !last_q);
                    last_d  = gnt_d;
                    we_d    = gnt_d ? we1 : we0;
                    addr_d  = gnt_d ? addr1 : addr0;
                    wdata_d = gnt_d ? wdata1 : wdata0;
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                bc_d    = 2'd3;
                state_d = we_q ? S_WBYTE : S_RD_REQ;
            end
            S_WBYTE: begin
                if (bc_q != 2'd0) begin
                    bc_d = bc_q - 2'd1;
                end else if (addr_q == 4'hF && GAP_CYCLES > 0) begin
                    gap_d   = GAP_LAST;
                    state_d = S_GAP;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_GAP: begin
                if (gap_q == 4'd0) state_d = S_DONE;
                else               gap_d   = gap_q - 4'd1;
            end
            S_RD_REQ: begin
                if (enout) begin
                    shift_d[{bc_q, 3'b000} +: 8] = dataout;
                    state_d = S_RD_LOW;
                end
            end
            S_RD_LOW: begin
                if (!enout) begin
                    if (bc_q != 2'd0) begin
                        bc_d    = bc_q - 2'd1;
                        state_d = S_RD_REQ;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
`ifdef IOARB_TIMEOUT_EN
        // A handshake that makes progress takes priority over an expiring wait
        if ((state_q == S_RD_REQ || state_q == S_RD_LOW) && state_d == state_q
            && tmo_q == TW'(TIMEOUT - 1)) begin
            state_d   = S_DONE;
            timed_out = 1'b1;
        end
        tmo_d = ((state_q == S_RD_REQ || state_q == S_RD_LOW) && state_d == state_q)
                ? tmo_q + 1'b1 : '0;
`endif
    end

    always_comb begin
        load_d   = (state_d == S_CMD) || (state_d == S_WBYTE);
        datain_d = 8'h00;
        if (state_d == S_CMD)        datain_d = {1'b0, 2'b01, ~we_d, addr_d};
        else if (state_d == S_WBYTE) datain_d = wdata_d[{bc_d, 3'b000} +: 8];
        ready_d  = (state_d == S_RD_REQ);
        ack0_d   = (state_d == S_DONE) && !gnt_d;
        ack1_d   = (state_d == S_DONE) && gnt_d;
        rdata_d  = rdata_q;
        if (state_d == S_DONE && !we_q) rdata_d = timed_out ? 32'd0 : shift_d;
`ifdef IOARB_TIMEOUT_EN
        err_d    = (state_d == S_DONE) && timed_out;
`else
        err_d    = 1'b0;
`endif
    end

    assign load   = load_q;
    assign datain = datain_q;
    assign ready  = ready_q;
    assign ack0   = ack0_q;
    assign ack1   = ack1_q;
    assign rdata  = rdata_q;
    assign err    = err_q;

endmodule

// File: tb/tb_ioports_cmd_arbiter.sv
// Bench for ioports_cmd_arbiter: expected bytes/acks queued at stimulus time, checked by a negedge monitor.
module tb_ioports_cmd_arbiter;

    localparam int GAP = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [3:0]  addr0 = 4'd0, addr1 = 4'd0;
    logic [31:0] wdata0 = 32'd0, wdata1 = 32'd0;
    logic        ack0, ack1, err, load, ready;
    logic [31:0] rdata;
    logic [7:0]  datain;
    logic        enout = 1'b0;
    logic [7:0]  dataout = 8'd0;

    ioports_cmd_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err),
        .load(load), .datain(datain), .ready(ready),
        .enout(enout), .dataout(dataout)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] b; int off; int min_gap; } byte_e;
    typedef struct { int who; logic [31:0] rd; logic er; int off; } ack_e;

    byte_e      exp_b[$];
    ack_e       exp_a[$];
    logic [7:0] rd_bytes[$];
    logic [31:0] cur_rdata = 32'd0;
    bit         port_stuck = 1'b0;
    int         checks = 0, errors = 0, cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_write(input int who, input logic [3:0] a, input logic [31:0] d, input int gap);
        logic [31:0] w;
        ack_e ae;
        w = d;
        exp_b.push_back('{{4'h2, a}, 0, gap});
        for (int i = 0; i < 4; i++) exp_b.push_back('{w[31-8*i -: 8], i + 1, 0});
        ae = '{who, cur_rdata, 1'b0, (a == 4'hF) ? 5 + GAP : 5};
        exp_a.push_back(ae);
    endtask

    task automatic push_read(input int who, input logic [3:0] a, input logic [31:0] d, input int gap);
        logic [31:0] w;
        w = d;
        exp_b.push_back('{{4'h3, a}, 0, gap});
        for (int i = 0; i < 4; i++) rd_bytes.push_back(w[31-8*i -: 8]);
        exp_a.push_back('{who, d, 1'b0, -1});
        cur_rdata = d;
    endtask

    task automatic run_req(input int who, input logic we, input logic [3:0] a, input logic [31:0] d);
        bit got;
        got = 1'b0;
        if (who == 0) begin we0 = we; addr0 = a; wdata0 = d; req0 = 1'b1; end
        else          begin we1 = we; addr1 = a; wdata1 = d; req1 = 1'b1; end
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ((who == 0 && ack0) || (who == 1 && ack1)) begin got = 1'b1; break; end
        end
        check($sformatf("ack_arrives_req%0d", who), 32'(got), 32'd1);
        if (who == 0) req0 = 1'b0; else req1 = 1'b0;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Port block model: raise enout with the next byte on ready, release when ready drops
    initial forever begin
        @(posedge clk);
        #1;
        if (reset || port_stuck) enout = 1'b0;
        else if (ready && !enout) begin
            enout   = 1'b1;
            dataout = (rd_bytes.size() > 0) ? rd_bytes.pop_front() : 8'hEE;
        end else if (!ready && enout) enout = 1'b0;
    end

    initial begin : monitor
        int last_load, cmd_cyc;
        bit have_last;
        byte_e be;
        ack_e  ae;
        have_last = 1'b0;
        last_load = 0;
        cmd_cyc   = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                have_last = 1'b0;
            end else begin
                if (load) begin
                    if (exp_b.size() == 0) begin
                        check("unexpected_load_datain", {24'd0, datain}, 32'hFFFF_FFFF);
                    end else begin
                        be = exp_b.pop_front();
                        check("datain_byte", {24'd0, datain}, {24'd0, be.b});
                        if (be.off == 0) begin
                            if (have_last) begin
                                checks++;
                                if (cyc - last_load - 1 < be.min_gap) begin
                                    errors++;
                                    $display("FAIL load_low_gap actual=%0d required>=%0d", cyc - last_load - 1, be.min_gap);
                                end
                            end
                            cmd_cyc = cyc;
                        end else begin
                            check("byte_cycle_offset", 32'(cyc - cmd_cyc), 32'(be.off));
                        end
                    end
                    last_load = cyc;
                    have_last = 1'b1;
                    if (ready) check("ready_with_load", 32'(ready), 32'd0);
                end
                if (ack0 || ack1) begin
                    check("single_ack", 32'(ack0 & ack1), 32'd0);
                    if (exp_a.size() == 0) begin
                        check("unexpected_ack", {30'd0, ack1, ack0}, 32'd0);
                    end else begin
                        ae = exp_a.pop_front();
                        check("ack_requester", 32'(ack1), 32'(ae.who));
                        check("rdata", rdata, ae.rd);
                        check("err", 32'(err), 32'(ae.er));
                        if (ae.off >= 0) check("ack_cycle_offset", 32'(cyc - cmd_cyc), 32'(ae.off));
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1);
    end

    initial begin : stim
        int acks, rcnt;
        bit found;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_load", 32'(load), 32'd0);
        check("rst_datain", {24'd0, datain}, 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_ack", {30'd0, ack1, ack0}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // single write, port 2
        push_write(0, 4'd2, 32'h1234_5678, 0);
        run_req(0, 1'b1, 4'd2, 32'h1234_5678);
        repeat (2) @(negedge clk);

        // port 15 write with req1 pending: dead time before the next command
        push_write(0, 4'hF, 32'h0000_000F, 2);
        push_write(1, 4'd3, 32'hA1B2_C3D4, GAP + 2);
        fork
            run_req(0, 1'b1, 4'hF, 32'h0000_000F);
            begin
                @(negedge clk);
                run_req(1, 1'b1, 4'd3, 32'hA1B2_C3D4);
            end
        join
        repeat (2) @(negedge clk);

        // read port 8 on requester 1
        push_read(1, 4'd8, 32'h2016_1702, 2);
        run_req(1, 1'b0, 4'd8, 32'h2016_1702);
        check("read_bytes_consumed", 32'(rd_bytes.size()), 32'd0);
        repeat (2) @(negedge clk);

        // both held from reset: grants alternate 0,1,0,1
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cur_rdata = 32'd0;
        push_write(0, 4'd5, 32'h1111_2222, 0);
        push_write(1, 4'd6, 32'h3333_4444, 2);
        push_write(0, 4'd5, 32'h1111_2222, 2);
        push_write(1, 4'd6, 32'h3333_4444, 2);
        we0 = 1'b1; addr0 = 4'd5; wdata0 = 32'h1111_2222;
        we1 = 1'b1; addr1 = 4'd6; wdata1 = 32'h3333_4444;
        req0 = 1'b1; req1 = 1'b1;
        acks = 0;
        for (int i = 0; i < 200 && acks < 4; i++) begin
            @(negedge clk);
            if (ack0 || ack1) acks++;
        end
        req0 = 1'b0; req1 = 1'b0;
        check("rr_ack_count", 32'(acks), 32'd4);
        repeat (3) @(negedge clk);

        // reset in the middle of a read after two bytes
        exp_b.push_back('{8'h34, 0, 2});
        for (int i = 0; i < 4; i++) rd_bytes.push_back(8'h50 + 8'(i));
        we0 = 1'b0; addr0 = 4'd4; req0 = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rd_bytes.size() == 2 && !enout && !ready) begin found = 1'b1; break; end
        end
        check("two_bytes_read", 32'(found), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_load", 32'(load), 32'd0);
        check("midrst_ready", 32'(ready), 32'd0);
        check("midrst_ack", {30'd0, ack1, ack0}, 32'd0);
        reset = 1'b0;
        req0 = 1'b0;
        rd_bytes.delete();
        cur_rdata = 32'd0;
        repeat (4) @(negedge clk);
        push_read(0, 4'd1, 32'hCAFE_0001, 0);
        run_req(0, 1'b0, 4'd1, 32'hCAFE_0001);
        repeat (2) @(negedge clk);

`ifdef IOARB_TIMEOUT_EN
        // enout never answers: timeout after 16 cycles of ready
        port_stuck = 1'b1;
        exp_b.push_back('{8'h39, 0, 2});
        exp_a.push_back('{0, 32'd0, 1'b1, 17});
        cur_rdata = 32'd0;
        rcnt = 0;
        fork
            run_req(0, 1'b0, 4'd9, 32'd0);
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (ready) rcnt++;
            end
        join
        check("timeout_ready_cycles", 32'(rcnt), 32'd16);
        port_stuck = 1'b0;
`else
        rcnt = 0;
`endif

        repeat (4) @(negedge clk);
        check("bytes_left", 32'(exp_b.size()), 32'd0);
        check("acks_left", 32'(exp_a.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ioports_cmd_arbiter.md
Name: ioports_cmd_arbiter

Overview:
- Master-side sequencer that shares the general-purpose I/O port block's byte command interface (load/datain out, ready/enout/dataout in) between two 32-bit requesters.
- Converts word-level read/write requests into the port block's byte protocol:
  - command byte, bits [6:4] = 010 for write, 011 for read; bits [3:0] = port address.
  - four data bytes, MS byte first.
- Round-robin arbitration. Honours the port-15 auto-clear dead time.

Parameters:
- GAP_CYCLES, 4, idle cycles (load low) inserted after the last byte of any write to port 15; range 0..15.
- TIMEOUT, 1024, max cycles waiting on one enout edge during a read (used only with IOARB_TIMEOUT_EN).

Ports:
- clk  in  1  master clock
- reset  in  1  synchronous, active-high reset
- req0, req1  in  1  request, held high until matching ack
- we0, we1  in  1  1 = write, 0 = read; sampled at grant
- addr0, addr1  in  4  port address; sampled at grant
- wdata0, wdata1  in  32  write data; sampled at grant
- ack0, ack1  out  1  one-cycle completion pulse
- rdata  out  32  read result; valid in the ack cycle, holds until the next ack
- err  out  1  timeout flag, valid with ack (constant 0 without the macro)
- load  out  1  byte strobe to the port block
- datain  out  8  byte to the port block
- ready  out  1  read-byte request to the port block
- enout  in  1  port block read-byte valid
- dataout  in  8  port block read byte

Behaviour:
- All outputs are registered.
- Reset values: load=0, datain=0, ready=0, ack0=ack1=0, rdata=0, err=0, state=IDLE, last-served=1 (so req0 wins first).
- Reset mid-transaction: abandon the transaction with no ack. The port block shares the same reset.
- Arbitration (IDLE only):
  - One requester high: grant it.
  - Both high: grant the one not served last.
  - On grant, latch we/addr/wdata and update last-served.
  - A req dropped mid-transaction is ignored; the transaction completes and acks.
- States: IDLE, CMD, WBYTE, GAP, RD_REQ, RD_LOW, DONE. A 2-bit byte counter bc runs 3..0.
- IDLE -> CMD on grant (cycle T).
- CMD: load=1, datain={1'b0, we?3'b010:3'b011, addr}; lasts one cycle.
  - Write: bc=3, go to WBYTE.
  - Read: go to RD_REQ.
- WBYTE: load=1, datain=wdata[8*bc+7 -: 8] for 4 consecutive cycles.
  - After bc=0: if addr==15 and GAP_CYCLES>0, go to GAP; else DONE.
- GAP: load=0 for exactly GAP_CYCLES cycles, then DONE.
- RD_REQ: ready=1 until enout==1. On that cycle capture dataout into shift byte bc, drop ready, go to RD_LOW.
- RD_LOW: ready=0 until enout==0.
  - bc>0: decrement bc, go to RD_REQ.
  - bc==0: go to DONE.
- DONE: ack of the granted requester =1 for one cycle. On a read, rdata is updated in the same cycle. Return to IDLE.
- Load is never high in GAP, RD_REQ, RD_LOW, DONE or IDLE.
- Write latency, addr≠15: load high cycles T+1..T+5, ack at T+6.
- Write latency, addr=15: ack at T+6+GAP_CYCLES.
- Earliest next grant is the cycle after ack. Consecutive transactions have at least 2 cycles with load low between them.

Optional Feature:
- IOARB_TIMEOUT_EN defined:
  - A counter runs in RD_REQ and RD_LOW and clears on every state change.
  - On reaching TIMEOUT: ready=0, go to DONE, ack with err=1, rdata=0.
- Not defined: wait indefinitely; err is tied to 0.

Test Plan:
- req0 write addr 2, data 0x12345678 -> load high 5 consecutive cycles with datain 0x22,0x12,0x34,0x56,0x78; ack0 at T+6; ack1 stays 0.
- req0 write addr 15 (0x0000000F), req1 write addr 3 pending -> load low ≥ GAP_CYCLES+2 cycles between byte 0x0F and command byte 0x23; ack0 at T+10.
- req1 read addr 8, bench port model returns 0x20161702 -> command byte 0x38; 4 full ready/enout handshakes; ack1 with rdata=0x20161702, err=0.
- req0 and req1 held high from reset for 4 transactions -> grant order 0,1,0,1; one ack per transaction.
- Reset asserted during read after 2 bytes -> next cycle load=0, ready=0, no ack. A following read to addr 1 completes correctly.
- IOARB_TIMEOUT_EN, TIMEOUT=16, enout stuck 0 -> ready drops 16 cycles after RD_REQ entry; ack0 with err=1, rdata=0.
